// File: rtl/smi_frame_steer_x2_pkg.sv
// Shared definitions for the SMI two-way frame steering block: FSM state
// encoding, Eofc field width and helpers for frame-end detection and Eofc masking.
package smi_frame_steer_x2_pkg;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    FwdA = 2'd1,
    FwdB = 2'd2
  } steerState_t;

  localparam int unsigned EofcWidth = 8;

  // A non-zero Eofc marks the last flit of a frame.
  function automatic logic lastFromEofc(input logic [EofcWidth-1:0] eofc);
    return eofc != '0;
  endfunction

  // Mask applied to Eofc on capture; wide enough for any byte count up to FlitWidth.
  function automatic logic [EofcWidth-1:0] eofcMask(input int unsigned flitWidth);
    return EofcWidth'(2 * flitWidth - 1);
  endfunction

endpackage

// File: rtl/smi_steer_out_fifo.sv
// Per-output FIFO for the SMI frame steerer. Stores {Eofc,Data} entries,
// async active-low reset, registered full/ready flags, wrapping pointers.
// A push while full is refused even if a pop frees a slot in the same cycle.
module smi_steer_out_fifo #(
  parameter int unsigned Width     = 24,
  parameter int unsigned Depth     = 16,
  parameter int unsigned IndexSize = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [Width-1:0] pushData,
  output logic             full,
  output logic             outReady,
  output logic [Width-1:0] outData,
  input  logic             outStop
);

  localparam logic [IndexSize-1:0] LastIndex = IndexSize'(Depth - 1);
  localparam logic [IndexSize:0]   FullCount = (IndexSize + 1)'(Depth);
  localparam logic [IndexSize:0]   OneCount  = (IndexSize + 1)'(1);

  logic [Width-1:0]     mem [Depth];
  logic [IndexSize-1:0] wrPtr;
  logic [IndexSize-1:0] rdPtr;
  logic [IndexSize:0]   count;
  logic [IndexSize:0]   countNext;
  logic                 doPush;
  logic                 doPop;

  assign doPush  = push & ~full;
  assign doPop   = outReady & ~outStop;
  assign outData = mem[rdPtr];

  // Occupancy after this cycle's push/pop.
  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + OneCount;
    end else if (!doPush && doPop) begin
      countNext = count - OneCount;
    end
  end

  // Storage write; contents need no reset since ready gates them.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushData;
    end
  end

  // Pointers, occupancy and registered status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      outReady <= 1'b0;
    end else begin
      if (doPush) begin
        wrPtr <= (wrPtr == LastIndex) ? '0 : wrPtr + IndexSize'(1);
      end
      if (doPop) begin
        rdPtr <= (rdPtr == LastIndex) ? '0 : rdPtr + IndexSize'(1);
      end
      count    <= countNext;
      full     <= (countNext == FullCount);
      outReady <= (countNext != '0);
    end
  end

endmodule

// File: rtl/smi_frame_steer_x2.sv
// SMI frame steerer: routes whole frames from one input to output A or B
// based on the RouteBit of each frame's first flit. Each output has its own
// FIFO so a stalled consumer only backpressures the input, never the other output.
// Optional build macro SMI_STEER_STATS_EN adds per-output frame counters.
module smi_frame_steer_x2
  import smi_frame_steer_x2_pkg::*;
#(
  parameter int unsigned FlitWidth     = 2,
  parameter int unsigned FifoSize      = 16,
  parameter int unsigned FifoIndexSize = 4,
  parameter int unsigned RouteBit      = 0
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   smiInReady,
  input  logic [EofcWidth-1:0]   smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutAReady,
  output logic [EofcWidth-1:0]   smiOutAEofc,
  output logic [FlitWidth*8-1:0] smiOutAData,
  input  logic                   smiOutAStop,
  output logic                   smiOutBReady,
  output logic [EofcWidth-1:0]   smiOutBEofc,
  output logic [FlitWidth*8-1:0] smiOutBData,
  input  logic                   smiOutBStop
`ifdef SMI_STEER_STATS_EN
  ,
  output logic [31:0]            frameCountA,
  output logic [31:0]            frameCountB
`endif
);

  localparam int unsigned          DataWidth  = FlitWidth * 8;
  localparam int unsigned          EntryWidth = EofcWidth + DataWidth;
  localparam logic [EofcWidth-1:0] EofcKeep   = eofcMask(FlitWidth);

  logic                  readyQ;
  logic [EofcWidth-1:0]  eofcQ;
  logic [DataWidth-1:0]  dataQ;
  logic                  lastQ;
  steerState_t           state;
  logic                  toB;
  logic                  halt;
  logic                  accept;
  logic                  pushA;
  logic                  pushB;
  logic                  fullA;
  logic                  fullB;
  logic [EntryWidth-1:0] entryA;
  logic [EntryWidth-1:0] entryB;

  // Destination for the flit in the input register: fresh route in Idle, locked otherwise.
  always_comb begin
    toB = 1'b0;
    unique case (state)
      Idle:    toB = dataQ[RouteBit];
      FwdA:    toB = 1'b0;
      FwdB:    toB = 1'b1;
      default: toB = 1'b0;
    endcase
  end

  assign halt      = toB ? fullB : fullA;
  assign accept    = readyQ & ~halt;
  assign pushA     = accept & ~toB;
  assign pushB     = accept & toB;
  assign smiInStop = readyQ & halt;

  // Input register: reloads whenever the held flit is not stalled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      readyQ <= 1'b0;
      eofcQ  <= '0;
      dataQ  <= '0;
      lastQ  <= 1'b0;
    end else if (!(readyQ && halt)) begin
      readyQ <= smiInReady;
      eofcQ  <= smiInEofc & EofcKeep;
      dataQ  <= smiInData;
      lastQ  <= lastFromEofc(smiInEofc);
    end
  end

  // Frame tracking: lock the route on a non-last first flit, release on the last flit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= Idle;
    end else if (accept) begin
      if (lastQ) begin
        state <= Idle;
      end else begin
        state <= toB ? FwdB : FwdA;
      end
    end
  end

  smi_steer_out_fifo #(
    .Width    (EntryWidth),
    .Depth    (FifoSize),
    .IndexSize(FifoIndexSize)
  ) uFifoA (
    .clk     (clk),
    .rstn    (rstn),
    .push    (pushA),
    .pushData({eofcQ, dataQ}),
    .full    (fullA),
    .outReady(smiOutAReady),
    .outData (entryA),
    .outStop (smiOutAStop)
  );

  smi_steer_out_fifo #(
    .Width    (EntryWidth),
    .Depth    (FifoSize),
    .IndexSize(FifoIndexSize)
  ) uFifoB (
    .clk     (clk),
    .rstn    (rstn),
    .push    (pushB),
    .pushData({eofcQ, dataQ}),
    .full    (fullB),
    .outReady(smiOutBReady),
    .outData (entryB),
    .outStop (smiOutBStop)
  );

  assign smiOutAEofc = entryA[EntryWidth-1 -: EofcWidth];
  assign smiOutAData = entryA[DataWidth-1:0];
  assign smiOutBEofc = entryB[EntryWidth-1 -: EofcWidth];
  assign smiOutBData = entryB[DataWidth-1:0];

`ifdef SMI_STEER_STATS_EN
  logic [31:0] frameCntA;
  logic [31:0] frameCntB;

  // Wrapping count of frame-ending flits pushed into each FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frameCntA <= '0;
      frameCntB <= '0;
    end else begin
      if (pushA && lastQ) frameCntA <= frameCntA + 32'd1;
      if (pushB && lastQ) frameCntB <= frameCntB + 32'd1;
    end
  end

  assign frameCountA = frameCntA;
  assign frameCountB = frameCntB;
`endif

endmodule
